// File: rtl/accum_rr_sched.sv
// Round-robin scheduler sharing one accumulator among NREQ burst requesters.
// Each granted burst is summed and presented with its requester id on a valid/ready port.
module accum_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int AW   = 8,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AW-1:0]      out_sum,
    output logic [IDW-1:0]     out_id,
    output logic               out_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;

    logic [DW-1:0]   data_a [NREQ];
    logic [2*NREQ-1:0] dbl_sh;
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  pick_chain [NREQ+1];
    logic [IDW-1:0]  pick_idx;
    logic            beat;
    logic [AW:0]     sum_ext;

    // rot[o] is the valid of requester (ptr+1+o) mod NREQ, i.e. priority order.
    assign dbl_sh = {req_valid, req_valid} >> ({1'b0, ptr_q} + (IDW+1)'(1));
    assign rot    = dbl_sh[NREQ-1:0];

    // Chain runs from lowest to highest priority so the nearest valid wins.
    assign pick_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pick
            localparam int OFF = NREQ - 1 - gi;
            logic [IDW:0]   raw;
            logic [IDW-1:0] abs_idx;
            assign raw     = {1'b0, ptr_q} + (IDW+1)'(OFF + 1);
            assign abs_idx = (raw >= (IDW+1)'(NREQ)) ? IDW'(raw - (IDW+1)'(NREQ))
                                                     : raw[IDW-1:0];
            assign pick_chain[gi+1] = rot[OFF] ? abs_idx : pick_chain[gi];
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
            assign data_a[gi] = req_data[gi*DW +: DW];
        end
    endgenerate
    assign pick_idx = pick_chain[NREQ];

    assign beat    = (state_q == S_BURST) && req_valid[gnt_q];
    assign sum_ext = {1'b0, acc_q} + {{(AW+1-DW){1'b0}}, data_a[gnt_q]};

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            gnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req_valid) state_d = S_GRANT;
            S_GRANT: state_d = S_BURST;
            S_BURST: if (beat && req_last[gnt_q]) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (state_q == S_IDLE && (|req_valid)) begin
            gnt_d = pick_idx;
            acc_d = '0;
            ovf_d = 1'b0;
        end
        if (beat) begin
            acc_d = sum_ext[AW-1:0];
            ovf_d = ovf_q | sum_ext[AW];
        end
        if (state_q == S_DONE && out_ready) begin
            ptr_d = gnt_q;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == S_BURST) && (gnt_q == IDW'(gi));
        end
    endgenerate

    always_comb begin
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out_sum   = acc_q;
        out_id    = gnt_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_accum_rr_sched.sv
// Directed bench for accum_rr_sched: latency, round-robin order, overflow, backpressure, reset abort.
module tb_accum_rr_sched;
    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int AW   = 8;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               res;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [AW-1:0]      out_sum;
    logic [IDW-1:0]     out_id;
    logic               out_ovf;
    logic               busy;

    int errors = 0;
    int checks = 0;

    accum_rr_sched #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) dut (
        .clk       (clk),
        .res       (res),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d, input logic l);
        req_data[i*DW +: DW] = d;
        req_last[i]          = l;
    endtask

    // Present one beat on requester i and return at the negedge after it is accepted.
    task automatic send_beat(input int i, input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        req_valid[i] = 1'b1;
        set_data(i, d, l);
        while (!req_ready[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("beat_timeout", n, 0);
        @(negedge clk);
        $display("beat req=%0d data=%0d last=%0b accepted", i, d, l);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDW-1:0] exp_ids [4];
        int nres, cyc, bad;

        res = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;

        // 1: reset and idle
        @(negedge clk); @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum",   out_sum,   0);
        chk("rst_id",    out_id,    0);
        chk("rst_ovf",   out_ovf,   0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy",  busy,      0);
        res = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_busy",  busy,      0);
            chk("idle_valid", out_valid, 0);
            chk("idle_ready", req_ready, 0);
        end
        $display("test1 reset/idle done");

        // 2: requester 0 burst 1,2,3
        out_ready = 1'b1;
        req_valid[0] = 1'b1;
        set_data(0, 4'd1, 1'b0);
        @(negedge clk);
        chk("t2_ready_grant", req_ready, 4'b0000);
        chk("t2_busy_grant",  busy,      1);
        @(negedge clk);
        chk("t2_ready_burst", req_ready, 4'b0001);
        @(negedge clk);
        set_data(0, 4'd2, 1'b0);
        @(negedge clk);
        set_data(0, 4'd3, 1'b1);
        chk("t2_valid_early", out_valid, 0);
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_sum",   out_sum,   6);
        chk("t2_id",    out_id,    0);
        chk("t2_ovf",   out_ovf,   0);
        chk("t2_ready_done", req_ready, 0);
        $display("result id=%0d sum=%0d ovf=%0b", out_id, out_sum, out_ovf);
        req_valid = '0; req_last = '0;
        @(negedge clk);
        chk("t2_valid_fall", out_valid, 0);

        // 3: requesters 1 and 3 alternate with single-beat bursts
        exp_ids[0] = 2'd1; exp_ids[1] = 2'd3; exp_ids[2] = 2'd1; exp_ids[3] = 2'd3;
        set_data(1, 4'd5, 1'b1);
        set_data(3, 4'd5, 1'b1);
        req_valid = 4'b1010;
        nres = 0; cyc = 0; bad = 0;
        while (nres < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if ($countones(req_ready) > 1) bad++;
            if (out_valid) begin
                $display("result id=%0d sum=%0d ovf=%0b", out_id, out_sum, out_ovf);
                chk("t3_id",  out_id,  exp_ids[nres]);
                chk("t3_sum", out_sum, 5);
                nres++;
                if (nres == 4) req_valid = '0;
            end
        end
        chk("t3_count",  nres, 4);
        chk("t3_onehot", bad,  0);
        req_last = '0;
        @(negedge clk);

        // 4: requester 2, 20 beats of 15 -> wrap and overflow
        for (int k = 0; k < 20; k++) send_beat(2, 4'd15, (k == 19));
        req_valid = '0; req_last = '0;
        chk("t4_valid", out_valid, 1);
        chk("t4_sum",   out_sum,   44);
        chk("t4_id",    out_id,    2);
        chk("t4_ovf",   out_ovf,   1);
        $display("result id=%0d sum=%0d ovf=%0b", out_id, out_sum, out_ovf);
        @(negedge clk);
        chk("t4_valid_fall", out_valid, 0);

        // 5: backpressure with a competing requester
        out_ready = 1'b0;
        set_data(1, 4'd9, 1'b1);
        req_valid[1] = 1'b1;
        send_beat(0, 4'd7, 1'b0);
        send_beat(0, 4'd8, 1'b1);
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_sum",   out_sum,   15);
            chk("t5_hold_id",    out_id,    0);
            chk("t5_hold_ready", req_ready, 0);
            @(negedge clk);
        end
        $display("result id=%0d sum=%0d ovf=%0b (released)", out_id, out_sum, out_ovf);
        out_ready = 1'b1;
        send_beat(1, 4'd9, 1'b1);
        chk("t5_next_valid", out_valid, 1);
        chk("t5_next_id",    out_id,    1);
        chk("t5_next_sum",   out_sum,   9);
        $display("result id=%0d sum=%0d ovf=%0b", out_id, out_sum, out_ovf);
        req_valid = '0; req_last = '0;
        @(negedge clk);

        // 6: reset mid-burst abandons it
        send_beat(0, 4'd3, 1'b0);
        send_beat(0, 4'd3, 1'b0);
        res = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy",  busy,      0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_sum",   out_sum,   0);
        res = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_result", out_valid, 0);
        end
        send_beat(0, 4'd4, 1'b1);
        chk("t6_valid", out_valid, 1);
        chk("t6_sum",   out_sum,   4);
        chk("t6_id",    out_id,    0);
        chk("t6_ovf",   out_ovf,   0);
        $display("result id=%0d sum=%0d ovf=%0b", out_id, out_sum, out_ovf);
        req_valid = '0; req_last = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accum_rr_sched.md
Name: accum_rr_sched

Overview:
- Round-robin scheduler that shares one accumulator datapath among NREQ requesters.
- Each requester sends a burst of DW-bit samples with valid/ready and marks the final beat with last.
- The scheduler locks the accumulator to the granted requester for the whole burst, then presents the sum with its requester id on a valid/ready output port.
- Sits between the sample producers and the downstream consumer of the accumulated totals.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 4, sample width
AW, 8, accumulator/result width (AW >= DW)
IDW, 2, requester id width (ceil log2 NREQ)

Ports:
clk  in  1  clock, rising edge
res  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester beat valid
req_data  in  NREQ*DW  per-requester sample; requester i occupies bits [i*DW +: DW]
req_last  in  NREQ  per-requester final-beat flag, qualified by valid
req_ready  out  NREQ  per-requester beat accept; one-hot or zero
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_sum  out  AW  burst sum, modulo 2^AW
out_id  out  IDW  index of the requester that produced out_sum
out_ovf  out  1  set if any carry out of AW bits occurred during the burst
busy  out  1  high in GRANT, BURST and DONE

Behaviour:
- Reset (asynchronous, res=1) forces:
  - state IDLE; acc=0; ovf=0
  - rr pointer = NREQ-1, so requester 0 has first priority
  - out_valid=0, out_sum=0, out_id=0, out_ovf=0, req_ready=0, busy=0
- FSM states: IDLE, GRANT, BURST, DONE.
- IDLE:
  - If any req_valid is high, select the first valid requester scanning ptr+1, ptr+2, ... modulo NREQ.
  - Register it as gnt, clear acc and ovf, go to GRANT.
  - No beat is accepted in this cycle.
- GRANT: one-cycle setup, then BURST. Gives a fixed 2-cycle latency from req_valid seen in IDLE to the first possible accept.
- BURST:
  - req_ready[gnt]=1; all other req_ready bits are 0.
  - On req_valid[gnt] & req_ready[gnt]:
    - acc <= acc + zero-extended req_data[gnt], wrapping modulo 2^AW
    - ovf <= ovf | carry-out
  - If req_last[gnt] is high on that same beat, go to DONE; the sum includes that beat.
  - If req_valid[gnt] is low, wait indefinitely; no timeout.
  - Valid/last from non-granted requesters are ignored.
- DONE:
  - out_valid=1, with out_sum=acc, out_id=gnt, out_ovf=ovf.
  - Outputs stay stable while out_valid & !out_ready.
  - On out_ready: ptr <= gnt, go to IDLE.
  - out_valid falls the cycle after the handshake.
  - No req_ready is asserted in DONE.
- Result timing: out_valid rises the cycle after the last beat is accepted.
- Minimum overhead per burst: IDLE + GRANT + DONE = 3 cycles beyond the data beats.
- A single-beat burst (valid & last on the first accepted beat) is legal.
- Fairness: a continuously requesting requester waits at most NREQ-1 bursts.
- Reset mid-operation: the in-flight burst is abandoned, no result is produced, and ptr returns to NREQ-1.
- Requesters must hold data/last stable while valid & !ready; the scheduler does not check this.

Test Plan:
1. Reset with res=1 for 2 cycles, then release with no requests -> all outputs 0, busy=0, state stays IDLE for 10 cycles.
2. Requester 0 sends a burst of 1, 2, 3 (last on 3), out_ready=1 -> out_valid pulses one cycle after the beat "3" is accepted; out_sum=6, out_id=0, out_ovf=0; req_ready[0] first high 2 cycles after req_valid[0] rises.
3. Requesters 1 and 3 both hold valid with single-beat bursts of data 5 (last=1) -> result ids in order 1, 3, 1, 3, each out_sum=5; req_ready never high for two requesters at once.
4. Requester 2 sends 20 beats of 15 -> out_sum=44 (300 mod 256), out_ovf=1, out_id=2.
5. Requester 0 burst 7, 8 with out_ready low for 5 cycles after out_valid rises -> out_valid, out_sum=15 and out_id=0 held stable; no req_ready asserted for requester 1 even though its valid is high; after out_ready=1, requester 1 is granted next.
6. Requester 0 sends beats 3, 3, then res pulses before last -> no out_valid; after release, requester 0 sends single beat 4 with last -> out_sum=4, out_id=0, out_ovf=0.
